// File: rtl/beam_i2s_tx_if.sv
// Producer-side port bundle for beam_i2s_tx: one stereo sum per accepted transfer.
// A transfer happens on every posedge where in_valid && in_ready; in_valid may be held
// while in_ready is low, and the sample must stay stable until it is accepted.
interface beam_i2s_tx_if #(
    parameter int SUM_WIDTH = 19
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [SUM_WIDTH-1:0] in_left;
    logic signed [SUM_WIDTH-1:0] in_right;

    modport master (output in_valid, output in_left, output in_right, input in_ready);
    modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/beam_i2s_tx.sv
// Beamformer output stage: FIFO of scaled stereo words serialised as I2S, one bit per clk.
// Define BEAM_I2S_TX_SAT_EN to clamp out-of-range words instead of wrapping them.
module beam_i2s_tx #(
    parameter int NUMBER_OF_BITS = 16,
    parameter int SUM_WIDTH      = 19,
    parameter int SHIFT          = 3,
    parameter int SLOT_BITS      = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    beam_i2s_tx_if.slave                    in_if,
    output logic                            ws_out,
    output logic                            sd_out,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            underflow,
    input  logic                            underflow_clr
);
    localparam int CW = $clog2(2 * SLOT_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(NUMBER_OF_BITS);
    localparam int EW = 2 * NUMBER_OF_BITS;

`ifdef BEAM_I2S_TX_SAT_EN
    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'((2 ** (NUMBER_OF_BITS - 1)) - 1);
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = SUM_WIDTH'(-(2 ** (NUMBER_OF_BITS - 1)));
`endif

    function automatic logic [NUMBER_OF_BITS-1:0] convert(input logic signed [SUM_WIDTH-1:0] x);
`ifdef BEAM_I2S_TX_SAT_EN
        logic signed [SUM_WIDTH-1:0] t;
        t = x >>> SHIFT;
        if (t > SAT_MAX) begin
            convert = SAT_MAX[NUMBER_OF_BITS-1:0];
        end else if (t < SAT_MIN) begin
            convert = SAT_MIN[NUMBER_OF_BITS-1:0];
        end else begin
            convert = t[NUMBER_OF_BITS-1:0];
        end
`else
        convert = NUMBER_OF_BITS'(x >>> SHIFT);
`endif
    endfunction

    logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
    logic [AW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]             count_q;
    logic [EW-1:0]             mem_q [FIFO_DEPTH];
    logic [NUMBER_OF_BITS-1:0] shadow_l_q, shadow_r_q;
    logic                      ws_q, sd_q, underflow_q;

    logic                      full, empty, push, pop, frame_end;
    logic                      right_slot, sd_d;
    logic [CW-1:0]             slot;
    int                        slot_i;
    logic [NUMBER_OF_BITS-1:0] word;
    logic [EW-1:0]             head;

    assign full      = (count_q == LW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign push      = in_if.in_valid && !full;
    assign frame_end = (bit_cnt_q == CW'(2 * SLOT_BITS - 1));
    assign pop       = frame_end && !empty;
    assign head      = mem_q[rd_ptr_q];

    assign in_if.in_ready = !full;
    assign ws_out         = ws_q;
    assign sd_out         = sd_q;
    assign fifo_level     = count_q;
    assign underflow      = underflow_q;

    // Slot position 0 is the I2S one-bit delay; positions past the word are padding.
    always_comb begin
        bit_cnt_d  = frame_end ? '0 : bit_cnt_q + CW'(1);
        right_slot = (bit_cnt_q >= CW'(SLOT_BITS));
        slot       = right_slot ? bit_cnt_q - CW'(SLOT_BITS) : bit_cnt_q;
        slot_i     = int'(slot);
        word       = right_slot ? shadow_r_q : shadow_l_q;
        sd_d       = 1'b0;
        if (slot_i >= 1 && slot_i <= NUMBER_OF_BITS) begin
            sd_d = word[IW'(NUMBER_OF_BITS - slot_i)];
        end
    end

    // Storage is left unreset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {convert(in_if.in_left), convert(in_if.in_right)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shadow_l_q  <= '0;
            shadow_r_q  <= '0;
            ws_q        <= 1'b0;
            sd_q        <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            ws_q      <= right_slot;
            sd_q      <= sd_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
            if (frame_end) begin
                if (empty) begin
                    shadow_l_q <= '0;
                    shadow_r_q <= '0;
                end else begin
                    shadow_l_q <= head[EW-1:NUMBER_OF_BITS];
                    shadow_r_q <= head[NUMBER_OF_BITS-1:0];
                end
            end
            // A fresh underflow takes priority over a clear in the same cycle.
            if (frame_end && empty) begin
                underflow_q <= 1'b1;
            end else if (underflow_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_beam_i2s_tx.sv
// Directed bench for beam_i2s_tx: idle framing, bit order, FIFO back-pressure,
// conversion, mid-frame reset and underflow flag priority.
module tb_beam_i2s_tx;
    localparam int NB = 16;
    localparam int SW = 19;
    localparam int SB = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       underflow_clr = 1'b0;
    logic       ws_out, sd_out, underflow;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;
    int bc = 0;

    beam_i2s_tx_if #(.SUM_WIDTH(SW)) bus ();

    beam_i2s_tx dut (
        .clk           (clk),
        .reset         (reset),
        .in_if         (bus),
        .ws_out        (ws_out),
        .sd_out        (sd_out),
        .fifo_level    (fifo_level),
        .underflow     (underflow),
        .underflow_clr (underflow_clr)
    );

    always #5 clk = ~clk;

    // bc is the bit position the next posedge will process.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        bc = (bc + 1) % (2 * SB);
    endtask

    task automatic run_to(input int target);
        for (int n = 0; n < 2 * 2 * SB && bc != target; n++) tick();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        underflow_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bc = 0;
    endtask

    function automatic logic exp_sd(input int j, input logic [NB-1:0] l, input logic [NB-1:0] r);
        int s;
        logic [NB-1:0] w;
        s = j % SB;
        w = (j >= SB) ? r : l;
        if (s >= 1 && s <= NB) return w[NB-s];
        return 1'b0;
    endfunction

    // Must start with bc == 0; returns the two words seen on sd_out for that frame.
    task automatic capture_frame(output logic [NB-1:0] l, output logic [NB-1:0] r);
        l = '0;
        r = '0;
        for (int j = 0; j < 2 * SB; j++) begin
            int s;
            s = j % SB;
            tick();
            checks++;
            if (ws_out !== (j >= SB)) begin
                errors++;
                $display("FAIL cap_ws bit %0d got %b exp %b", j, ws_out, (j >= SB));
            end
            if (s >= 1 && s <= NB) begin
                if (j < SB) l[NB-s] = sd_out;
                else        r[NB-s] = sd_out;
            end else begin
                checks++;
                if (sd_out !== 1'b0) begin
                    errors++;
                    $display("FAIL cap_pad bit %0d got %b exp 0", j, sd_out);
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ws_out, sd_out, fifo_level, underflow, bus.in_ready} !== 7'b00_000_0_1) begin
            errors++;
            $display("FAIL reset_vals got ws=%b sd=%b lvl=%0d uf=%b rdy=%b exp 0 0 0 0 1",
                     ws_out, sd_out, fifo_level, underflow, bus.in_ready);
        end
        reset = 1'b0;
        bc = 0;
        for (int k = 0; k < 2 * SB; k++) begin
            tick();
            checks++;
            if (ws_out !== (k >= SB) || sd_out !== 1'b0) begin
                errors++;
                $display("FAIL idle bit %0d got ws=%b sd=%b exp ws=%b sd=0", k, ws_out, sd_out, (k >= SB));
            end
            if (k == 2 * SB - 2) begin
                checks++;
                if (underflow !== 1'b0) begin
                    errors++;
                    $display("FAIL uf_early got %b exp 0", underflow);
                end
            end
        end
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_first_load got %b exp 1", underflow);
        end
    endtask

    task automatic test_bit_order;
        do_reset();
        bus.in_left  = 19'sd8;
        bus.in_right = -19'sd8;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++;
            $display("FAIL push_level got %0d exp 1", fifo_level);
        end
        run_to(0);
        checks++;
        if (fifo_level !== 3'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL pop_level got lvl=%0d uf=%b exp 0 0", fifo_level, underflow);
        end
        for (int j = 0; j < 2 * SB; j++) begin
            tick();
            checks++;
            if (ws_out !== (j >= SB) || sd_out !== exp_sd(j, 16'h0001, 16'hFFFF)) begin
                errors++;
                $display("FAIL bits bit %0d got ws=%b sd=%b exp ws=%b sd=%b",
                         j, ws_out, sd_out, (j >= SB), exp_sd(j, 16'h0001, 16'hFFFF));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [NB-1:0] l, r;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.in_left  = 19'(8 * (i + 1));
            bus.in_right = 19'(-8 * (i + 1));
            bus.in_valid = 1'b1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready %0d got %b exp 1", i, bus.in_ready);
            end
            tick();
            checks++;
            if (fifo_level !== 3'(i + 1)) begin
                errors++;
                $display("FAIL b2b_level %0d got %0d exp %0d", i, fifo_level, i + 1);
            end
        end
        bus.in_left  = 19'sd40;
        bus.in_right = -19'sd40;
        run_to(2 * SB - 1);
        checks++;
        if (fifo_level !== 3'd4 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full got lvl=%0d rdy=%b exp 4 0", fifo_level, bus.in_ready);
        end
        tick();
        checks++;
        if (fifo_level !== 3'd3 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_after_pop got lvl=%0d rdy=%b exp 3 1", fifo_level, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd4 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fifth got lvl=%0d rdy=%b exp 4 0", fifo_level, bus.in_ready);
        end
        run_to(0);
        for (int i = 1; i <= 4; i++) begin
            capture_frame(l, r);
            checks++;
            if (l !== 16'(i + 1) || r !== 16'(-(i + 1))) begin
                errors++;
                $display("FAIL b2b_frame %0d got l=%h r=%h exp l=%h r=%h", i, l, r, 16'(i + 1), 16'(-(i + 1)));
            end
            checks++;
            if (underflow !== (i == 4)) begin
                errors++;
                $display("FAIL b2b_uf %0d got %b exp %b", i, underflow, (i == 4));
            end
        end
        capture_frame(l, r);
        checks++;
        if (l !== 16'h0000 || r !== 16'h0000 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL silence got l=%h r=%h lvl=%0d exp 0000 0000 0", l, r, fifo_level);
        end
    endtask

    task automatic test_conversion;
        logic signed [SW-1:0] vl [3];
        logic signed [SW-1:0] vr [3];
        logic [NB-1:0]        el [3];
        logic [NB-1:0]        er [3];
        logic [NB-1:0]        l, r;
        vl = '{19'h3FFFF, 19'h40000, 19'h7FFFF};
        vr = '{19'h60000, 19'h00007, 19'h7FFF7};
        el = '{16'h7FFF, 16'h8000, 16'hFFFF};
        er = '{16'hC000, 16'h0000, 16'hFFFE};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.in_left  = vl[i];
            bus.in_right = vr[i];
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        run_to(0);
        for (int i = 0; i < 3; i++) begin
            capture_frame(l, r);
            checks++;
            if (l !== el[i] || r !== er[i]) begin
                errors++;
                $display("FAIL conv %0d got l=%h r=%h exp l=%h r=%h", i, l, r, el[i], er[i]);
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [NB-1:0] l, r;
        do_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_left  = 19'(64 * (i + 1));
            bus.in_right = 19'(-64 * (i + 1));
            tick();
        end
        bus.in_valid = 1'b0;
        run_to(40);
        checks++;
        if (fifo_level !== 3'd2 || ws_out !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got lvl=%0d ws=%b exp 2 1", fifo_level, ws_out);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({ws_out, sd_out, fifo_level, bus.in_ready, underflow} !== 7'b00_000_1_0) begin
            errors++;
            $display("FAIL mid_reset got ws=%b sd=%b lvl=%0d rdy=%b uf=%b exp 0 0 0 1 0",
                     ws_out, sd_out, fifo_level, bus.in_ready, underflow);
        end
        reset = 1'b0;
        bc = 0;
        capture_frame(l, r);
        checks++;
        if (l !== 16'h0000 || r !== 16'h0000 || underflow !== 1'b1 || fifo_level !== 3'd0) begin
            errors++;
            $display("FAIL post_reset got l=%h r=%h uf=%b lvl=%0d exp 0000 0000 1 0", l, r, underflow, fifo_level);
        end
    endtask

    task automatic test_underflow_clr;
        run_to(2 * SB - 1);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_set got %b exp 1", underflow);
        end
        run_to(5);
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_alone got %b exp 0", underflow);
        end
        run_to(2 * SB - 1);
        tick();
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_reset got %b exp 1", underflow);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_left  = '0;
        bus.in_right = '0;
        test_reset();
        test_bit_order();
        test_back_to_back();
        test_conversion();
        test_reset_midframe();
        test_underflow_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
